// File: rtl/cpu_pkg.sv
// Shared types and widths for the CPU memory-port arbiter.
package cpu_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_RESP} arb_state_t;

    typedef enum logic {REQ_CPU, REQ_DBG} req_id_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/grant/response bundle between the two requesters, the arbiter and the memory.
interface mem_port_arbiter_if;
    import cpu_pkg::*;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_lock;

    logic              cpu_gnt;
    logic              dbg_gnt;
    logic              cpu_rvalid;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] rdata;

    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_add;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        input  mem_dout,
        output cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, rdata,
        output mem_rd, mem_wr, mem_add, mem_din
    );

    // Requesters and memory side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        output mem_dout,
        input  cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, rdata,
        input  mem_rd, mem_wr, mem_add, mem_din
    );

endinterface

// File: rtl/rr2_pick.sv
// Combinational 2-way round-robin picker: on a tie the requester not granted last wins.
module rr2_pick
    import cpu_pkg::*;
(
    input  logic [1:0] elig,  // bit 0 = CPU, bit 1 = debug
    input  req_id_t    last,
    output req_id_t    win,
    output logic       valid
);

    always_comb begin
        valid = |elig;
        win   = REQ_CPU;
        if (elig == 2'b11) begin
            win = (last == REQ_CPU) ? REQ_DBG : REQ_CPU;
        end else if (elig[1]) begin
            win = REQ_DBG;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port data memory between the CPU core and the debug loader.
// Round-robin with a debug lock; each access takes an ISSUE cycle then a RESP cycle.
module mem_port_arbiter
    import cpu_pkg::*;
(
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    arb_state_t        state_q;
    req_id_t           last_q;
    req_id_t           win_q;
    logic              we_q;
    logic              cpu_gnt_q;
    logic              dbg_gnt_q;
    logic              cpu_rvalid_q;
    logic              dbg_rvalid_q;
    logic              mem_rd_q;
    logic              mem_wr_q;
    logic [ADDR_W-1:0] mem_add_q;
    logic [DATA_W-1:0] mem_din_q;

    logic [1:0]        elig;
    req_id_t           pick_win;
    logic              pick_valid;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Lock only masks the CPU at arbitration; an access already issued runs to completion.
    assign elig = {bus.dbg_req, bus.cpu_req & ~bus.dbg_lock};

    rr2_pick u_pick (
        .elig  (elig),
        .last  (last_q),
        .win   (pick_win),
        .valid (pick_valid)
    );

    assign sel_we    = (pick_win == REQ_DBG) ? bus.dbg_we    : bus.cpu_we;
    assign sel_addr  = (pick_win == REQ_DBG) ? bus.dbg_addr  : bus.cpu_addr;
    assign sel_wdata = (pick_win == REQ_DBG) ? bus.dbg_wdata : bus.cpu_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ARB_IDLE;
            last_q       <= REQ_DBG;
            win_q        <= REQ_CPU;
            we_q         <= 1'b0;
            cpu_gnt_q    <= 1'b0;
            dbg_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_add_q    <= '0;
            mem_din_q    <= '0;
        end else begin
            // Grants, strobes and rvalid are single-cycle pulses.
            cpu_gnt_q    <= 1'b0;
            dbg_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            case (state_q)
                ARB_ISSUE: begin
                    state_q      <= ARB_RESP;
                    cpu_rvalid_q <= ~we_q & (win_q == REQ_CPU);
                    dbg_rvalid_q <= ~we_q & (win_q == REQ_DBG);
                end
                ARB_IDLE, ARB_RESP: begin
                    if (pick_valid) begin
                        state_q   <= ARB_ISSUE;
                        win_q     <= pick_win;
                        last_q    <= pick_win;
                        we_q      <= sel_we;
                        mem_add_q <= sel_addr;
                        mem_din_q <= sel_wdata;
                        mem_rd_q  <= ~sel_we;
                        mem_wr_q  <= sel_we;
                        cpu_gnt_q <= (pick_win == REQ_CPU);
                        dbg_gnt_q <= (pick_win == REQ_DBG);
                    end else begin
                        state_q <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign bus.cpu_gnt    = cpu_gnt_q;
    assign bus.dbg_gnt    = dbg_gnt_q;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.dbg_rvalid = dbg_rvalid_q;
    assign bus.mem_rd     = mem_rd_q;
    assign bus.mem_wr     = mem_wr_q;
    assign bus.mem_add    = mem_add_q;
    assign bus.mem_din    = mem_din_q;
    // Memory output only reaches rdata during a read response.
    assign bus.rdata      = (cpu_rvalid_q | dbg_rvalid_q) ? bus.mem_dout : '0;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential two-requester arbiter that shares the CPU's single-port 32x8 synchronous memory between the CPU core (instruction fetch and data access) and a debug/program-loader port. It sits between the core's address/data mux and `Memory`, and owns the `mem_rd`/`mem_wr`/`mem_add`/`mem_din` strobes. Access is granted round-robin with a debug lock, and read data is returned with a valid pulse.

## Interface
- `ADDR_W`, 5: memory address width.
- `DATA_W`, 8: memory data width.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cpu_req`, `dbg_req`  in  1 each  access request; held with attributes stable until the cycle after the matching `gnt`.
- `cpu_we`, `dbg_we`  in  1 each  1 = write, 0 = read.
- `cpu_addr`, `dbg_addr`  in  ADDR_W each  access address.
- `cpu_wdata`, `dbg_wdata`  in  DATA_W each  write data.
- `dbg_lock`  in  1  while high, CPU requests are never granted.
- `cpu_gnt`, `dbg_gnt`  out  1 each  one-cycle grant pulse, registered.
- `cpu_rvalid`, `dbg_rvalid`  out  1 each  one-cycle read-data-valid pulse, registered.
- `rdata`  out  DATA_W  read data, shared; meaningful only with an `rvalid`.
- `mem_rd`, `mem_wr`  out  1 each  memory strobes, registered, never both high.
- `mem_add`  out  ADDR_W  memory address, registered.
- `mem_din`  out  DATA_W  memory write data, registered.
- `mem_dout`  in  DATA_W  memory read data; valid the cycle after `mem_rd`.

## Operation
- FSM `ARB_IDLE`, `ARB_ISSUE`, `ARB_RESP`. Reset state is `ARB_IDLE`.
- IDLE or RESP, at the clock edge: sample eligible requests. CPU is eligible if `cpu_req & !dbg_lock`; debug is eligible if `dbg_req`.
  - No eligible request: go to IDLE.
  - Otherwise pick a winner and go to ISSUE.
  - Register the winner's id, `we`, `addr` and `wdata` into `mem_add`/`mem_din`, and set `mem_rd = !we` or `mem_wr = we`.
- ISSUE: assert the winner's `gnt` and the registered memory strobe for exactly this cycle, then go to RESP.
- RESP: strobes are low. If the issued access was a read, assert the winner's `rvalid` and drive `rdata = mem_dout`. Arbitrate again in the same cycle, as in IDLE.
- Winner selection, 2-way round-robin:
  - Only one eligible requester: it wins.
  - Both eligible: the requester not granted last wins.
  - The `last` pointer resets to debug, so CPU wins the first tie.
  - `last` updates only on a grant.
- Writes produce no `rvalid`. A write is complete at the memory edge ending its ISSUE cycle.
- A requester drops `req` in RESP, the cycle after seeing `gnt`. If it keeps `req` high, that is a new request and is arbitrated normally.
- Raising `dbg_lock` while the CPU access is in ISSUE or RESP does not abort it. Lock only masks new arbitration.
- Reset asserted mid-access: all outputs go low immediately and asynchronously. A pending `rvalid` is lost and the FSM returns to IDLE. A write whose ISSUE cycle was interrupted is not guaranteed to land.

## Timing
- Reset values: all `gnt`, `rvalid`, `mem_rd` and `mem_wr` are 0. `mem_add`, `mem_din` and `rdata` are 0. State is IDLE and `last` is debug.
- Latency from `req` high before edge N:
  - `gnt` and memory strobe in cycle N+1, when the arbiter was idle.
  - `rvalid` in cycle N+2.
- Peak throughput: one access every 2 cycles (ISSUE/RESP alternating back-to-back).
- Worst-case wait for an unlocked requester: one access of the other requester, i.e. 2 cycles, plus its own 2.
- Outputs are registered except `rdata`, which is a combinational path from `mem_dout` qualified by the registered RESP/read flag.

## Structure
- Shared `cpu_pkg`:
  - `ADDR_W`, `DATA_W` constants.
  - `arb_state_t` enum (`ARB_IDLE`, `ARB_ISSUE`, `ARB_RESP`).
  - `req_id_t` enum (`REQ_CPU`, `REQ_DBG`).
- One sub-module, `rr2_pick`: combinational 2-way round-robin picker. Inputs are the eligible vector and `last`; outputs are winner id and valid. The FSM, the `last` register and the strobe/data registers live in `mem_port_arbiter`.

## Test plan
- CPU read only: addr 5h0A, memory holds 8h3C → `cpu_gnt` and `mem_rd`/`mem_add=0A` one cycle later, then `cpu_rvalid` with `rdata=3C` the next cycle. `dbg_*` outputs stay 0.
- Debug write, then CPU read, same address: dbg writes 8hA5 to 5h1F, then CPU reads 5h1F → `mem_wr`/`mem_din=A5`, no `dbg_rvalid`, then CPU `rdata=A5`.
- Simultaneous reads held continuously (CPU 5h01, dbg 5h02) → grants alternate CPU, dbg, CPU, dbg every 2 cycles; CPU wins first.
- `dbg_lock=1` with both requesting, for 4 accesses → only debug is granted. Drop the lock → CPU is granted at the next arbitration.
- Reset pulse during RESP of a CPU read → all outputs 0 immediately, no `cpu_rvalid`, state IDLE. A new request after reset is served with normal latency.
- Random mixed traffic against a memory model → `mem_rd & mem_wr` never both high. Every read returns the model value. No requester waits more than 4 cycles unless it is the CPU under `dbg_lock`.
